arp_rx: RTL and testbench

- Receive-side ARP parser. Consumes the ARP payload delivered by the MAC receive stage, after the Ethernet header is stripped and the frame is already classified as EtherType 0x0806.
- Validates the payload and checks whether the target IP is ours.
- Drives the ARP transmitter's reply trigger, reply MAC and destination IP.
- Publishes learned IP/MAC pairs to the ARP cache.

---
 rtl/arp_rx.sv | 140 ++++++++++++++
 tb/tb_arp_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/arp_rx.sv
// Receive-side ARP payload parser: validates the frame, triggers replies to requests for our IP,
// and publishes learned IP/MAC pairs. Optional macro ARP_RX_GRATUITOUS_EN enables gratuitous learning.
module arp_rx #(
   parameter logic [31:0] P_SRC_IP = {8'd192, 8'd168, 8'd10, 8'd1}
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_src_ip,
   input  logic        i_src_ip_valid,
   input  logic [7:0]  i_mac_data,
   input  logic        i_mac_valid,
   input  logic        i_mac_last,
   output logic        o_trig_reply,
   output logic [47:0] o_reply_mac,
   output logic [31:0] o_dst_ip,
   output logic        o_dst_ip_valid,
   output logic [31:0] o_learn_ip,
   output logic [47:0] o_learn_mac,
   output logic        o_learn_valid
);

   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] local_ip_q, local_ip_d;
   logic [15:0] htype_q, htype_d;
   logic [15:0] ptype_q, ptype_d;
   logic [7:0]  hlen_q, hlen_d;
   logic [7:0]  plen_q, plen_d;
   logic [15:0] op_q, op_d;
   logic [47:0] sha_q, sha_d;
   logic [31:0] spa_q, spa_d;
   logic [31:0] tpa_q, tpa_d;

   logic        trig_q, trig_d;
   logic        learn_valid_q, learn_valid_d;
   logic [47:0] reply_mac_q, reply_mac_d;
   logic [31:0] dst_ip_q, dst_ip_d;
   logic [31:0] learn_ip_q, learn_ip_d;
   logic [47:0] learn_mac_q, learn_mac_d;

   logic frame_end, fmt_ok, for_us, is_req, is_rep, grat;

   // Byte counter and field capture. Multi-byte fields shift in MSB first, so every
   // field is completely rewritten by each frame that reaches it.
   always_comb begin
      cnt_d   = cnt_q;
      htype_d = htype_q;
      ptype_d = ptype_q;
      hlen_d  = hlen_q;
      plen_d  = plen_q;
      op_d    = op_q;
      sha_d   = sha_q;
      spa_d   = spa_q;
      tpa_d   = tpa_q;
      if (i_mac_valid) begin
         if (cnt_q <= 6'd1)                        htype_d = {htype_q[7:0], i_mac_data};
         else if (cnt_q <= 6'd3)                   ptype_d = {ptype_q[7:0], i_mac_data};
         else if (cnt_q == 6'd4)                   hlen_d  = i_mac_data;
         else if (cnt_q == 6'd5)                   plen_d  = i_mac_data;
         else if (cnt_q <= 6'd7)                   op_d    = {op_q[7:0], i_mac_data};
         else if (cnt_q <= 6'd13)                  sha_d   = {sha_q[39:0], i_mac_data};
         else if (cnt_q <= 6'd17)                  spa_d   = {spa_q[23:0], i_mac_data};
         else if (cnt_q >= 6'd24 && cnt_q <= 6'd27) tpa_d  = {tpa_q[23:0], i_mac_data};

         if (i_mac_last)              cnt_d = 6'd0;
         else if (cnt_q != 6'd63)     cnt_d = cnt_q + 6'd1;
      end
   end

   // Decision uses the *_d fields so a last byte at index 27 still contributes its target-IP byte.
   assign frame_end = i_mac_valid & i_mac_last & (cnt_q >= 6'd27);
   assign fmt_ok    = (htype_d == 16'h0001) & (ptype_d == 16'h0800) &
                      (hlen_d == 8'd6) & (plen_d == 8'd4);
   assign for_us    = (tpa_d == local_ip_q);
   assign is_req    = (op_d == 16'd1);
   assign is_rep    = (op_d == 16'd2);

`ifdef ARP_RX_GRATUITOUS_EN
   assign grat = frame_end & fmt_ok & ~for_us & (spa_d == tpa_d) &
                 (spa_d != local_ip_q) & (is_req | is_rep);
`else
   assign grat = 1'b0;
`endif

   always_comb begin
      local_ip_d    = i_src_ip_valid ? i_src_ip : local_ip_q;
      trig_d        = frame_end & fmt_ok & for_us & is_req;
      learn_valid_d = (frame_end & fmt_ok & for_us & (is_req | is_rep)) | grat;
      reply_mac_d   = trig_d ? sha_d : reply_mac_q;
      dst_ip_d      = trig_d ? spa_d : dst_ip_q;
      learn_mac_d   = learn_valid_d ? sha_d : learn_mac_q;
      learn_ip_d    = learn_valid_d ? spa_d : learn_ip_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q         <= '0;
         local_ip_q    <= P_SRC_IP;
         htype_q       <= '0;
         ptype_q       <= '0;
         hlen_q        <= '0;
         plen_q        <= '0;
         op_q          <= '0;
         sha_q         <= '0;
         spa_q         <= '0;
         tpa_q         <= '0;
         trig_q        <= 1'b0;
         learn_valid_q <= 1'b0;
         reply_mac_q   <= '0;
         dst_ip_q      <= '0;
         learn_ip_q    <= '0;
         learn_mac_q   <= '0;
      end else begin
         cnt_q         <= cnt_d;
         local_ip_q    <= local_ip_d;
         htype_q       <= htype_d;
         ptype_q       <= ptype_d;
         hlen_q        <= hlen_d;
         plen_q        <= plen_d;
         op_q          <= op_d;
         sha_q         <= sha_d;
         spa_q         <= spa_d;
         tpa_q         <= tpa_d;
         trig_q        <= trig_d;
         learn_valid_q <= learn_valid_d;
         reply_mac_q   <= reply_mac_d;
         dst_ip_q      <= dst_ip_d;
         learn_ip_q    <= learn_ip_d;
         learn_mac_q   <= learn_mac_d;
      end
   end

   assign o_trig_reply   = trig_q;
   assign o_dst_ip_valid = trig_q;
   assign o_reply_mac    = reply_mac_q;
   assign o_dst_ip       = dst_ip_q;
   assign o_learn_valid  = learn_valid_q;
   assign o_learn_ip     = learn_ip_q;
   assign o_learn_mac    = learn_mac_q;

endmodule

// File: tb/tb_arp_rx.sv
// Bench for arp_rx: frame-level model over a byte queue, per-cycle output compare, directed frames.
module tb_arp_rx;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_src_ip;
   logic        i_src_ip_valid;
   logic [7:0]  i_mac_data;
   logic        i_mac_valid;
   logic        i_mac_last;
   logic        o_trig_reply;
   logic [47:0] o_reply_mac;
   logic [31:0] o_dst_ip;
   logic        o_dst_ip_valid;
   logic [31:0] o_learn_ip;
   logic [47:0] o_learn_mac;
   logic        o_learn_valid;

   arp_rx dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_src_ip(i_src_ip), .i_src_ip_valid(i_src_ip_valid),
      .i_mac_data(i_mac_data), .i_mac_valid(i_mac_valid), .i_mac_last(i_mac_last),
      .o_trig_reply(o_trig_reply), .o_reply_mac(o_reply_mac),
      .o_dst_ip(o_dst_ip), .o_dst_ip_valid(o_dst_ip_valid),
      .o_learn_ip(o_learn_ip), .o_learn_mac(o_learn_mac), .o_learn_valid(o_learn_valid)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   int n_trig = 0;
   int n_learn = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Frame-level model: collect the whole payload, then decide from the byte indices.
   logic [7:0]  mq[$];
   logic        m_trig, m_lvalid;
   logic [47:0] m_rmac, m_lmac;
   logic [31:0] m_dip, m_lip, m_local;

   task model_eval();
      logic [15:0] ht, pt, op;
      logic [47:0] sha;
      logic [31:0] spa, tpa;
      bit fmt, opok;
      if (mq.size() < 28) return;
      ht  = {mq[0], mq[1]};
      pt  = {mq[2], mq[3]};
      op  = {mq[6], mq[7]};
      sha = {mq[8], mq[9], mq[10], mq[11], mq[12], mq[13]};
      spa = {mq[14], mq[15], mq[16], mq[17]};
      tpa = {mq[24], mq[25], mq[26], mq[27]};
      fmt  = (ht == 16'h0001) && (pt == 16'h0800) && (mq[4] == 8'd6) && (mq[5] == 8'd4);
      opok = (op == 16'd1) || (op == 16'd2);
      if (fmt && opok && tpa == m_local) begin
         m_lvalid = 1'b1; m_lip = spa; m_lmac = sha;
         if (op == 16'd1) begin
            m_trig = 1'b1; m_rmac = sha; m_dip = spa;
         end
      end
`ifdef ARP_RX_GRATUITOUS_EN
      else if (fmt && opok && spa == tpa && tpa != m_local) begin
         m_lvalid = 1'b1; m_lip = spa; m_lmac = sha;
      end
`endif
   endtask

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mq.delete();
         m_trig = 0; m_lvalid = 0; m_rmac = 0; m_lmac = 0; m_dip = 0; m_lip = 0;
         m_local = {8'd192, 8'd168, 8'd10, 8'd1};
      end else begin
         m_trig = 0; m_lvalid = 0;
         if (i_mac_valid) begin
            mq.push_back(i_mac_data);
            if (i_mac_last) begin
               model_eval();
               mq.delete();
            end
         end
         if (i_src_ip_valid) m_local = i_src_ip;
      end
   end

   always @(negedge i_clk) begin
      chk("trig_reply", 48'(o_trig_reply), 48'(m_trig));
      chk("dst_ip_valid", 48'(o_dst_ip_valid), 48'(m_trig));
      chk("learn_valid", 48'(o_learn_valid), 48'(m_lvalid));
      chk("reply_mac", o_reply_mac, m_rmac);
      chk("dst_ip", 48'(o_dst_ip), 48'(m_dip));
      chk("learn_ip", 48'(o_learn_ip), 48'(m_lip));
      chk("learn_mac", o_learn_mac, m_lmac);
      if (o_trig_reply) n_trig++;
      if (o_learn_valid) n_learn++;
   end

   logic [7:0] fr[$];

   task automatic build(input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                        input logic [31:0] tpa, input logic [15:0] ht, input int len);
      fr.delete();
      fr.push_back(ht[15:8]); fr.push_back(ht[7:0]);
      fr.push_back(8'h08); fr.push_back(8'h00);
      fr.push_back(8'd6); fr.push_back(8'd4);
      fr.push_back(op[15:8]); fr.push_back(op[7:0]);
      for (int i = 0; i < 6; i++) fr.push_back(sha[47-8*i -: 8]);
      for (int i = 0; i < 4; i++) fr.push_back(spa[31-8*i -: 8]);
      for (int i = 0; i < 6; i++) fr.push_back(8'h00);
      for (int i = 0; i < 4; i++) fr.push_back(tpa[31-8*i -: 8]);
      while (fr.size() < len) fr.push_back(8'hA5);
      while (fr.size() > len) void'(fr.pop_back());
   endtask

   task automatic send(input bit gaps, input bit ipload, input logic [31:0] newip, input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         @(posedge i_clk); #1;
         i_mac_valid    = 1'b1;
         i_mac_data     = fr[i];
         i_mac_last     = (i == fr.size() - 1);
         i_src_ip_valid = ipload && (i == fr.size() - 1);
         i_src_ip       = newip;
         if (gaps && i != fr.size() - 1) begin
            @(posedge i_clk); #1;
            i_mac_valid = 1'b0; i_mac_last = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk); #1;
         i_mac_valid = 1'b0; i_mac_last = 1'b0; i_src_ip_valid = 1'b0;
      end
   endtask

   int learn0;

   initial begin
      i_rst = 1'b1; i_src_ip = '0; i_src_ip_valid = 1'b0;
      i_mac_data = '0; i_mac_valid = 1'b0; i_mac_last = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      chk("reset reply_mac", o_reply_mac, 48'h0);
      chk("reset learn_ip", 48'(o_learn_ip), 48'h0);

      // Request for us
      build(16'd1, 48'h001122334455, 32'hC0A80A00, 32'hC0A80A01, 16'h0001, 46);
      send(0, 0, 0, 46); idle(3);
      chk("req reply_mac", o_reply_mac, 48'h001122334455);
      chk("req dst_ip", 48'(o_dst_ip), 48'hC0A80A00);
      chk("req learn_mac", o_learn_mac, 48'h001122334455);
      chk("req n_trig", 48'(n_trig), 48'd1);
      chk("req n_learn", 48'(n_learn), 48'd1);

      // Reply to us
      build(16'd2, 48'hAABBCCDDEE01, 32'hC0A80A07, 32'hC0A80A01, 16'h0001, 46);
      send(0, 0, 0, 46); idle(3);
      chk("rep learn_mac", o_learn_mac, 48'hAABBCCDDEE01);
      chk("rep learn_ip", 48'(o_learn_ip), 48'hC0A80A07);
      chk("rep reply_mac held", o_reply_mac, 48'h001122334455);
      chk("rep n_trig", 48'(n_trig), 48'd1);
      chk("rep n_learn", 48'(n_learn), 48'd2);

      // Foreign target, bad htype, short frame then back-to-back valid request
      build(16'd1, 48'h0000DEADBEEF, 32'hC0A80A03, 32'hC0A80A09, 16'h0001, 46);
      send(0, 0, 0, 46); idle(2);
      build(16'd1, 48'h0000DEADBEEF, 32'hC0A80A03, 32'hC0A80A01, 16'h0002, 46);
      send(0, 0, 0, 46); idle(2);
      chk("foreign n_trig", 48'(n_trig), 48'd1);
      build(16'd1, 48'h0000DEADBEEF, 32'hC0A80A03, 32'hC0A80A01, 16'h0001, 20);
      send(0, 0, 0, 20);
      build(16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80A02, 32'hC0A80A01, 16'h0001, 28);
      send(0, 0, 0, 28); idle(3);
      chk("short n_trig", 48'(n_trig), 48'd2);
      chk("short reply_mac", o_reply_mac, 48'h0A0B0C0D0E0F);

      // Gapped request followed directly by another request
      build(16'd1, 48'h112233445566, 32'hC0A80A21, 32'hC0A80A01, 16'h0001, 30);
      send(1, 0, 0, 30);
      build(16'd1, 48'h665544332211, 32'hC0A80A22, 32'hC0A80A01, 16'h0001, 28);
      send(0, 0, 0, 28); idle(3);
      chk("b2b n_trig", 48'(n_trig), 48'd4);
      chk("b2b dst_ip", 48'(o_dst_ip), 48'hC0A80A22);

      // IP change in the decision cycle uses the old IP
      build(16'd1, 48'h123456789ABC, 32'hC0A80A30, 32'hC0A80A05, 16'h0001, 28);
      send(0, 1, 32'hC0A80A05, 28); idle(3);
      chk("ipchg n_trig", 48'(n_trig), 48'd4);
      send(0, 0, 0, 28); idle(3);
      chk("ipnew n_trig", 48'(n_trig), 48'd5);
      chk("ipnew reply_mac", o_reply_mac, 48'h123456789ABC);

      // Reset mid-frame
      build(16'd1, 48'h0F0E0D0C0B0A, 32'hC0A80A40, 32'hC0A80A01, 16'h0001, 28);
      send(0, 0, 0, 10);
      @(posedge i_clk); #1;
      i_mac_valid = 1'b0; i_rst = 1'b1;
      @(posedge i_clk); #1 i_rst = 1'b0;
      idle(2);
      chk("rst reply_mac", o_reply_mac, 48'h0);
      chk("rst learn_mac", o_learn_mac, 48'h0);
      chk("rst n_trig", 48'(n_trig), 48'd5);
      send(0, 0, 0, 28); idle(3);
      chk("post-rst n_trig", 48'(n_trig), 48'd6);
      chk("post-rst dst_ip", 48'(o_dst_ip), 48'hC0A80A40);

      // Gratuitous ARP
      learn0 = n_learn;
      build(16'd1, 48'h020406080A0C, 32'hC0A80A14, 32'hC0A80A14, 16'h0001, 28);
      send(0, 0, 0, 28); idle(3);
      chk("grat n_trig", 48'(n_trig), 48'd6);
`ifdef ARP_RX_GRATUITOUS_EN
      chk("grat n_learn", 48'(n_learn - learn0), 48'd1);
      chk("grat learn_ip", 48'(o_learn_ip), 48'hC0A80A14);
`else
      chk("grat n_learn", 48'(n_learn - learn0), 48'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
